// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding and the LFSR/MISR step
// functions, written over a wide vector so any register width up to MAX_W can use them.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_W = 64;

  // Callers zero-extend into MAX_W and cast the result back to their own width.
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] v,
                                                 input logic [MAX_W-1:0] poly);
    return (v << 1) | MAX_W'(^(v & poly));
  endfunction

  function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] v,
                                                 input logic [MAX_W-1:0] poly,
                                                 input logic [MAX_W-1:0] d);
    return lfsr_step(v, poly) ^ d;
  endfunction

endpackage

// File: rtl/bist_pattern_ctrl_if.sv
// Connection between the BIST controller and the circuit under test plus its
// status consumer; master is the controller side.
interface bist_pattern_ctrl_if #(
  parameter int PI_W = 35,
  parameter int PO_W = 23
);
  logic            start;
  logic [PI_W-1:0] pi_out;
  logic [PO_W-1:0] po_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [PO_W-1:0] sig;

  modport master (input start, po_in, output pi_out, busy, done, pass, sig);
  modport slave  (output start, po_in, input pi_out, busy, done, pass, sig);
endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register; clear wins over enable. Kept generic so
// other benchmark wrappers can reuse it with their own width and taps.
module bist_misr
  import bist_pkg::*;
#(
  parameter int              PO_W    = 23,
  parameter logic [PO_W-1:0] PO_POLY = 23'h42_0001
) (
  input  logic            ck,
  input  logic            rstn,
  input  logic            clr,
  input  logic            en,
  input  logic [PO_W-1:0] d,
  output logic [PO_W-1:0] q
);

  // Signature register
  always_ff @(posedge ck) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= PO_W'(misr_step(MAX_W'(q), MAX_W'(PO_POLY), MAX_W'(d)));
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST controller: drives CUT inputs from an LFSR, compacts CUT outputs into a
// MISR after a fixed CUT latency, and flags the final signature against a golden value.
module bist_pattern_ctrl
  import bist_pkg::*;
#(
  parameter int              PI_W       = 35,
  parameter int              PO_W       = 23,
  parameter logic [PI_W-1:0] PI_POLY    = 35'h5_0000_0001,
  parameter logic [PI_W-1:0] PI_SEED    = 35'h1,
  parameter logic [PO_W-1:0] PO_POLY    = 23'h42_0001,
  parameter int              N_PATTERNS = 256,
  parameter int              CUT_LAT    = 1,
  parameter logic [PO_W-1:0] GOLDEN_SIG = 23'h0
) (
  input logic                 ck,
  input logic                 rstn,
  bist_pattern_ctrl_if.master bus
);

  localparam int               CNT_W      = $clog2(N_PATTERNS + 1);
  localparam int               PIPE_W     = (CUT_LAT > 0) ? CUT_LAT : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(N_PATTERNS - 1);
  localparam logic [3:0]       DRAIN_LAST = 4'(CUT_LAT - 1);
  // An all-zero seed would lock the LFSR.
  localparam logic [PI_W-1:0]  SEED_EFF   = (PI_SEED == '0) ? PI_W'(1'b1) : PI_SEED;

  state_t            state_r, state_s;
  logic [PI_W-1:0]   lfsr_r, pi_out_r;
  logic [CNT_W-1:0]  count_r;
  logic [3:0]        drain_r;
  logic [PIPE_W-1:0] pipe_r;
  logic              busy_r, done_r, pass_r;
  logic              start_run_s, applied_s, misr_en_s, finish_s;
  logic [PO_W-1:0]   sig_s, sig_next_s;

  // Next-state decode and per-cycle strobes
  always_comb begin
    state_s     = state_r;
    start_run_s = 1'b0;
    applied_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          state_s     = RUN;
          start_run_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        applied_s = 1'b1;
        if (count_r == LAST_CNT) begin
          state_s = (CUT_LAT > 0) ? DRAIN : DONE;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Compaction enable plus look-ahead signature so PASS rises together with DONE
  always_comb begin
    finish_s   = (state_s == DONE) && (state_r != DONE);
    misr_en_s  = (CUT_LAT == 0) ? applied_s : pipe_r[PIPE_W-1];
    sig_next_s = sig_s;
    if (misr_en_s) begin
      sig_next_s = PO_W'(misr_step(MAX_W'(sig_s), MAX_W'(PO_POLY), MAX_W'(bus.po_in)));
    end else begin
      sig_next_s = sig_s;
    end
  end

  // State, pattern generator, counters, capture pipe and status flags
  always_ff @(posedge ck) begin
    if (!rstn) begin
      state_r  <= IDLE;
      lfsr_r   <= '0;
      pi_out_r <= '0;
      count_r  <= '0;
      drain_r  <= 4'd0;
      pipe_r   <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN) || (state_s == DRAIN);
      done_r  <= (state_s == DONE);
      pipe_r  <= PIPE_W'({pipe_r, applied_s});
      drain_r <= (state_r == DRAIN) ? drain_r + 4'd1 : 4'd0;
      if (start_run_s) begin
        pi_out_r <= SEED_EFF;
        lfsr_r   <= PI_W'(lfsr_step(MAX_W'(SEED_EFF), MAX_W'(PI_POLY)));
        count_r  <= '0;
      end else if (applied_s && (state_s == RUN)) begin
        pi_out_r <= lfsr_r;
        lfsr_r   <= PI_W'(lfsr_step(MAX_W'(lfsr_r), MAX_W'(PI_POLY)));
        count_r  <= count_r + CNT_W'(1'b1);
      end else begin
        pi_out_r <= pi_out_r;
        lfsr_r   <= lfsr_r;
        count_r  <= count_r;
      end
      if (start_run_s) begin
        pass_r <= 1'b0;
      end else if (finish_s) begin
        pass_r <= (sig_next_s == GOLDEN_SIG);
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  bist_misr #(
    .PO_W    (PO_W),
    .PO_POLY (PO_POLY)
  ) u_misr (
    .ck   (ck),
    .rstn (rstn),
    .clr  (start_run_s),
    .en   (misr_en_s),
    .d    (bus.po_in),
    .q    (sig_s)
  );

  assign bus.pi_out = pi_out_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.pass   = pass_r;
  assign bus.sig    = sig_s;

endmodule
